// File: rtl/hazard_detect.sv
// Hazard detection: raises load-use, branch-window and store-wait stall requests
// for the downstream stall controller.
module hazard_detect #(
  parameter int LOAD_BUBBLES  = 1,
  parameter int BRANCH_LAT    = 2,
  parameter int STORE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_branch,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       mem_store,
  input  logic       dmem_ready,
  input  logic       flush,
  output logic       StallLoad,
  output logic       StallStore,
  output logic       StallBranch,
  output logic       store_err
);

  localparam int LW = $clog2(LOAD_BUBBLES + 1);
  localparam int BW = $clog2(BRANCH_LAT + 1);
  localparam int WW = $clog2(STORE_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} storeState_t;

  storeState_t    stateReg, stateNext;
  logic [LW-1:0]  loadCntReg, loadCntNext;
  logic [BW-1:0]  brCntReg, brCntNext;
  logic [WW-1:0]  waitCntReg, waitCntNext;
  logic           storeErrReg, storeErrNext;
  logic           hit, brStart;

  // Input terms are gated by rst_n so every request reads 0 while in reset.
  always_comb begin
    hit = rst_n & id_valid & ex_mem_read & (ex_rd != 5'd0) &
          ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    StallLoad   = rst_n & ~flush & (hit | (loadCntReg != '0));
    brStart     = rst_n & id_valid & id_branch & (brCntReg == '0) & ~StallLoad & ~flush;
    StallBranch = rst_n & ~flush & (brStart | (brCntReg != '0));
    StallStore  = rst_n & mem_store & ~dmem_ready & (stateReg != S_ERR);
    store_err   = storeErrReg;
  end

  always_comb begin
    loadCntNext  = loadCntReg;
    brCntNext    = brCntReg;
    waitCntNext  = waitCntReg;
    stateNext    = stateReg;
    storeErrNext = storeErrReg;

    // An active window ignores new hits; it only reloads once it has drained.
    if (flush)
      loadCntNext = '0;
    else if (loadCntReg != '0)
      loadCntNext = loadCntReg - 1'b1;
    else if (hit)
      loadCntNext = LW'(LOAD_BUBBLES - 1);

    if (flush)
      brCntNext = '0;
    else if (brStart)
      brCntNext = BW'(BRANCH_LAT - 1);
    else if (brCntReg != '0)
      brCntNext = brCntReg - 1'b1;

    unique case (stateReg)
      S_IDLE: begin
        if (mem_store && !dmem_ready) begin
          stateNext   = S_WAIT;
          waitCntNext = WW'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready || !mem_store) begin
          stateNext   = S_IDLE;
          waitCntNext = '0;
        end else if (waitCntReg == WW'(STORE_TIMEOUT - 1)) begin
          stateNext    = S_ERR;
          storeErrNext = 1'b1;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
        end
      end
      S_ERR: begin
        // The store has been abandoned; wait for MEM to drop it.
        if (!mem_store) begin
          stateNext   = S_IDLE;
          waitCntNext = '0;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadCntReg  <= '0;
      brCntReg    <= '0;
      waitCntReg  <= '0;
      stateReg    <= S_IDLE;
      storeErrReg <= 1'b0;
    end else begin
      loadCntReg  <= loadCntNext;
      brCntReg    <= brCntNext;
      waitCntReg  <= waitCntNext;
      stateReg    <= stateNext;
      storeErrReg <= storeErrNext;
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
// Randomised scoreboard bench for hazard_detect with a cycle-level reference model.
module tb_hazard_detect;
  localparam int LB = 2;
  localparam int BL = 3;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_branch = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic ex_mem_read = 0, mem_store = 0, dmem_ready = 0, flush = 0;
  logic StallLoad, StallStore, StallBranch, store_err;

  hazard_detect #(.LOAD_BUBBLES(LB), .BRANCH_LAT(BL), .STORE_TIMEOUT(ST)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_store(mem_store),
    .dmem_ready(dmem_ready), .flush(flush), .StallLoad(StallLoad),
    .StallStore(StallStore), .StallBranch(StallBranch), .store_err(store_err));

  always #5 clk = ~clk;

  typedef struct packed {logic l; logic s; logic b; logic e;} exp_t;
  exp_t expQ[$];
  int   cycQ[$];
  int   total = 0;
  int   bad = 0;
  int   cycNo = 0;
  bit   stimDone = 0;

  // Reference model: remaining stall cycles of each window, cycles a store has
  // been stalled, whether it was abandoned, and the sticky error.
  int loadLeft = 0, brLeft = 0, storeStalled = 0;
  bit abandoned = 0, errSeen = 0;

  task automatic cyc(input bit rn, input bit iv, input int rs1, input int rs2,
                     input bit u1, input bit u2, input bit br, input bit ld,
                     input int rd, input bit ms, input bit dr, input bit fl);
    exp_t e;
    bit h;
    @(posedge clk);
    #1;
    rst_n = rn; id_valid = iv; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_branch = br; ex_mem_read = ld;
    ex_rd = 5'(rd); mem_store = ms; dmem_ready = dr; flush = fl;
    cycNo++;
    if (!rn) begin
      loadLeft = 0; brLeft = 0; storeStalled = 0; abandoned = 0; errSeen = 0;
      e = '0;
    end else begin
      h = iv && ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.l = !fl && (h || loadLeft > 0);
      e.b = !fl && ((iv && br && brLeft == 0 && !e.l) || brLeft > 0);
      e.s = ms && !dr && !abandoned;
      e.e = errSeen;
      if (fl) loadLeft = 0;
      else if (loadLeft > 0) loadLeft--;
      else if (h) loadLeft = LB - 1;
      if (fl) brLeft = 0;
      else if (brLeft > 0) brLeft--;
      else if (e.b) brLeft = BL - 1;
      if (e.s) begin
        storeStalled++;
        if (storeStalled == ST) begin
          abandoned = 1; errSeen = 1;
        end
      end else begin
        storeStalled = 0;
        if (!ms) abandoned = 0;
      end
    end
    expQ.push_back(e);
    cycQ.push_back(cycNo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int c, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, c, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a result; pop and compare.
  initial begin
    exp_t e;
    int c;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        c = cycQ.pop_front();
        chk("StallLoad", c, StallLoad, e.l);
        chk("StallStore", c, StallStore, e.s);
        chk("StallBranch", c, StallBranch, e.b);
        chk("store_err", c, store_err, e.e);
        $display("cycle %0d: load=%b store=%b branch=%b err=%b", c,
                 StallLoad, StallStore, StallBranch, store_err);
      end
    end
  end

  initial begin
    // reset with active inputs: everything masked
    cyc(0, 1, 5, 5, 1, 1, 1, 1, 5, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // load-use on rs2, then rd=0 and unused rs2 variants
    cyc(1, 1, 0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    idle(3);
    cyc(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    idle(2);
    // branch pulse
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(4);
    // branch with simultaneous hit, held in ID until the hazard clears
    cyc(1, 1, 7, 0, 1, 0, 1, 1, 7, 0, 0, 0);
    cyc(1, 1, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(4);
    // store wait of three cycles
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    // store timeout, then drop the store
    repeat (6) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // flush inside a branch window while a store stalls
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    // reset in the middle of a branch window (store_err is set here)
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(199) != 0, $urandom_range(3) != 0,
          $urandom_range(3), $urandom_range(3), $urandom_range(1), $urandom_range(1),
          $urandom_range(3) == 0, $urandom_range(1), $urandom_range(3),
          $urandom_range(1), $urandom_range(4) == 0, $urandom_range(9) == 0);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_detect.md
# hazard_detect

Hazard detection stage feeding the pipeline stall controller. It watches the ID, EX and MEM stages and generates the three request lines `StallLoad`, `StallStore` and `StallBranch`; the stall controller turns them into the 6-bit per-stage stall vector. The block resolves three things:
- load-use data hazards, with a multi-cycle bubble counter;
- branch resolution windows, with a latency counter;
- store/data-memory handshake waits, with a timeout watchdog.

## Interface
Parameters:
- `LOAD_BUBBLES`, 1: cycles `StallLoad` is held per detected load-use hazard (≥1).
- `BRANCH_LAT`, 2: cycles `StallBranch` is held per branch entering ID (≥1).
- `STORE_TIMEOUT`, 16: maximum consecutive cycles `StallStore` may be held (≥2).

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID stage holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5  ID source register indices.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction actually reads rs1/rs2.
- `id_branch`  in  1  the ID instruction is a branch or jump.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_rd`  in  5  EX destination register.
- `mem_store`  in  1  MEM stage holds a store request.
- `dmem_ready`  in  1  data memory accepts the store this cycle.
- `flush`  in  1  pipeline redirect from EX; kills pending load/branch stall state.
- `StallLoad`  out  1  load-use stall request.
- `StallStore`  out  1  store-wait stall request.
- `StallBranch`  out  1  branch-resolution stall request.
- `store_err`  out  1  sticky store-timeout flag.

## Operation
**Load-use detection**
- `hit` = `id_valid & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- `StallLoad` = `!flush & (hit | load_cnt != 0)`.
- When `hit & load_cnt == 0 & !flush`: `load_cnt <= LOAD_BUBBLES-1`.
- While `load_cnt != 0`: decrement by 1 per cycle; `hit` is ignored for reload.

**Branch window**
- `br_start` = `id_valid & id_branch & br_cnt == 0 & !StallLoad & !flush`.
- `StallBranch` = `!flush & (br_start | br_cnt != 0)`.
- On `br_start`: `br_cnt <= BRANCH_LAT-1`. Otherwise decrement while nonzero.
- A branch that also has a load-use hazard stalls for the load first. `StallBranch` is never raised in a cycle where `StallLoad` starts. This is required because the stall controller gives branch priority and would otherwise let ID advance past the hazard.

**Store wait FSM**
- States: `S_IDLE`, `S_WAIT`, `S_ERR`.
- `S_IDLE`:
  - `mem_store & !dmem_ready` → `S_WAIT`, with `wait_cnt <= 1`.
  - Otherwise stay in `S_IDLE`.
- `S_WAIT`:
  - `dmem_ready` or `!mem_store` → `S_IDLE`.
  - Else, if `wait_cnt == STORE_TIMEOUT-1` → `S_ERR` and set `store_err`.
  - Else increment `wait_cnt`.
- `S_ERR`: `StallStore` is forced to 0 and the store is abandoned. The FSM returns to `S_IDLE` when `mem_store` drops. `store_err` stays at 1 until reset.
- `StallStore` = `mem_store & !dmem_ready & state != S_ERR`. This is combinational, so it is asserted in the first wait cycle.
- The MEM stage holds `mem_store` stable while `StallStore` = 1.

**Interactions**
- All three requests are independent and may be asserted together. The downstream stall controller owns the priority between them.
- `flush` clears `load_cnt` and `br_cnt` to 0 synchronously. It does not affect the store FSM, because the store is older than the redirecting branch.

## Timing
- Reset (async, `rst_n` = 0): `load_cnt` = 0, `br_cnt` = 0, `wait_cnt` = 0, state `S_IDLE`, `store_err` = 0.
- During reset, `StallLoad`, `StallBranch` and `StallStore` are all 0. Input terms are masked while `rst_n` is low.
- Latency: every stall request rises in the same cycle as the triggering input (combinational path), with no added latency.
- Counters extend stalls to exact lengths:
  - `StallLoad` is high for exactly `LOAD_BUBBLES` cycles per hazard.
  - `StallBranch` is high for exactly `BRANCH_LAT` cycles per branch.
- Back-to-back events:
  - A new `hit` in the cycle after `load_cnt` reaches 0 starts a new window with no gap.
  - The same rule applies to `br_start`.
- `flush` in the middle of a window: the stall output drops in the `flush` cycle itself, and the counters read 0 on the next edge.
- Store timeout: at most `STORE_TIMEOUT` cycles of `StallStore`. `store_err` rises on the edge that ends the last stalled cycle.
- Reset asserted mid-window or mid-wait: all state clears immediately, including a set `store_err`.

## Test plan
- **Load-use:** `LOAD_BUBBLES`=2, `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for one cycle → `StallLoad` high for exactly 2 cycles. Repeat with `ex_rd`=0, or with `id_use_rs2`=0 → `StallLoad` stays 0.
- **Branch:** `BRANCH_LAT`=2, `id_branch` pulse → `StallBranch` high for 2 cycles. Branch with a simultaneous load-use hit → `StallLoad` high and `StallBranch` 0 in that cycle. `StallBranch` starts only after the hazard clears.
- **Store wait:** `mem_store`=1 with `dmem_ready`=0 for 3 cycles, then 1 → `StallStore` high for 3 cycles, low in the `dmem_ready` cycle, state back to `S_IDLE`.
- **Store timeout:** `STORE_TIMEOUT`=4 and `dmem_ready` held 0 → `StallStore` high for 4 cycles, then 0. `store_err`=1 and stays 1 after `mem_store` drops, until `rst_n` pulse.
- **Flush:** `flush` in cycle 1 of a 3-cycle branch window → `StallBranch` 0 from the `flush` cycle onward, while a concurrent `StallStore` is unaffected.
- **Reset:** async `rst_n` low mid-window → all outputs 0 immediately. After release with idle inputs → all outputs 0.
